// File: rtl/cdce62002_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdce62002_responder: SPI target for CDCE62002 programming frames with     |
// | 32-bit LSB-first decode and optional read-back (CDCE62002_RESPONDER_READBACK_EN). |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cdce62002_responder #(
  parameter logic [27:0] REG0_INIT = 28'h0000000,
  parameter logic [27:0] REG1_INIT = 28'h0000000
) (
  input  logic        sysclk,
  input  logic        reset_INV,
  input  logic        spi_clk,
  input  logic        spi_le,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [27:0] reg0,
  output logic [27:0] reg1,
  output logic        write_strobe,
  output logic [3:0]  write_addr,
  output logic        eeprom_strobe,
  output logic        frame_error,
  output logic [7:0]  frame_count
);

  localparam logic [5:0] C_FRAME_BITS = 6'd32;
  localparam logic [5:0] C_CNT_SAT    = 6'd33;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  logic [1:0]  r_clk_sync;
  logic [1:0]  r_le_sync;
  logic [1:0]  r_mosi_sync;
  logic        r_clk_hist;
  logic        r_le_hist;

  logic        w_clk_rise;
  logic        w_le_rise;
  logic        w_le_fall;
  logic        w_mosi;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_start;
  logic        w_shift_en;
  logic        w_commit;
  logic        w_frame_ok;

  logic [31:0] r_shift;
  logic [5:0]  r_bit_cnt;
  logic [3:0]  w_addr;
  logic [27:0] w_data;

  logic [27:0] r_reg0;
  logic [27:0] r_reg1;
  logic        r_write_strobe;
  logic [3:0]  r_write_addr;
  logic        r_eeprom_strobe;
  logic        r_frame_error;
  logic [7:0]  r_frame_count;

  // Sync flops reset low so an spi_le held low through reset never looks like a falling edge.
  always_ff @(posedge sysclk) begin
    if (!reset_INV) begin
      r_clk_sync  <= 2'b00;
      r_le_sync   <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_clk_hist  <= 1'b0;
      r_le_hist   <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], spi_clk};
      r_le_sync   <= {r_le_sync[0], spi_le};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
      r_clk_hist  <= r_clk_sync[1];
      r_le_hist   <= r_le_sync[1];
    end
  end

  assign w_clk_rise = r_clk_sync[1] & ~r_clk_hist;
  assign w_le_rise  = r_le_sync[1] & ~r_le_hist;
  assign w_le_fall  = ~r_le_sync[1] & r_le_hist;
  assign w_mosi     = r_mosi_sync[1];

  always_ff @(posedge sysclk) begin
    if (!reset_INV) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_le_fall) begin
          w_start     = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A clock edge coincident with the latch edge still contributes its bit.
        w_shift_en = w_clk_rise;
        if (w_le_rise) begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!reset_INV) begin
      r_shift   <= 32'h0000_0000;
      r_bit_cnt <= 6'd0;
    end else if (w_start) begin
      r_shift   <= 32'h0000_0000;
      r_bit_cnt <= 6'd0;
    end else if (w_shift_en) begin
      r_shift <= {w_mosi, r_shift[31:1]};
      if (r_bit_cnt != C_CNT_SAT) begin
        r_bit_cnt <= r_bit_cnt + 6'd1;
      end
    end
  end

  assign w_frame_ok = w_commit & (r_bit_cnt == C_FRAME_BITS);
  assign w_addr     = r_shift[3:0];
  assign w_data     = r_shift[31:4];

  always_ff @(posedge sysclk) begin
    if (!reset_INV) begin
      r_reg0          <= REG0_INIT;
      r_reg1          <= REG1_INIT;
      r_write_strobe  <= 1'b0;
      r_write_addr    <= 4'h0;
      r_eeprom_strobe <= 1'b0;
      r_frame_error   <= 1'b0;
      r_frame_count   <= 8'd0;
    end else begin
      r_write_strobe  <= 1'b0;
      r_eeprom_strobe <= 1'b0;
      if (w_commit && !w_frame_ok) begin
        r_frame_error <= 1'b1;
      end
      if (w_frame_ok) begin
        r_write_addr  <= w_addr;
        r_frame_count <= r_frame_count + 8'd1;
        case (w_addr)
          4'h0: begin
            r_reg0         <= w_data;
            r_write_strobe <= 1'b1;
          end
          4'h1: begin
            r_reg1         <= w_data;
            r_write_strobe <= 1'b1;
          end
          4'hF: begin
            r_eeprom_strobe <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign reg0          = r_reg0;
  assign reg1          = r_reg1;
  assign write_strobe  = r_write_strobe;
  assign write_addr    = r_write_addr;
  assign eeprom_strobe = r_eeprom_strobe;
  assign frame_error   = r_frame_error;
  assign frame_count   = r_frame_count;

`ifdef CDCE62002_RESPONDER_READBACK_EN
  // Shadows are only observable through read-back, so they exist only in this build.
  logic [27:0] r_shadow0;
  logic [27:0] r_shadow1;
  logic        r_rb_armed;
  logic [1:0]  r_rb_sel;
  logic [31:0] r_tx;
  logic        r_miso;
  logic [27:0] w_rb_field;
  logic [31:0] w_rb_word;
  logic        w_clk_fall;

  assign w_clk_fall = ~r_clk_sync[1] & r_clk_hist;

  always_comb begin
    w_rb_field = r_reg0;
    case (r_rb_sel)
      2'd0:    w_rb_field = r_reg0;
      2'd1:    w_rb_field = r_reg1;
      2'd2:    w_rb_field = r_shadow0;
      default: w_rb_field = r_shadow1;
    endcase
  end

  assign w_rb_word = {w_rb_field, 4'h0};

  always_ff @(posedge sysclk) begin
    if (!reset_INV) begin
      r_shadow0  <= REG0_INIT;
      r_shadow1  <= REG1_INIT;
      r_rb_armed <= 1'b0;
      r_rb_sel   <= 2'd0;
      r_tx       <= 32'h0000_0000;
      r_miso     <= 1'b0;
    end else begin
      if (w_frame_ok && (w_addr == 4'hF)) begin
        r_shadow0 <= r_reg0;
        r_shadow1 <= r_reg1;
      end
      if (w_start && r_rb_armed) begin
        r_tx   <= w_rb_word;
        r_miso <= w_rb_word[0];
      end else if ((r_state == S_SHIFT) && w_clk_fall && r_rb_armed) begin
        r_tx   <= {1'b0, r_tx[31:1]};
        r_miso <= r_tx[1];
      end
      // Disarm on any commit; a new addr-E frame in the read-back frame re-arms.
      if (w_commit) begin
        r_rb_armed <= 1'b0;
        r_miso     <= 1'b0;
        if (w_frame_ok && (w_addr == 4'hE)) begin
          r_rb_armed <= 1'b1;
          r_rb_sel   <= w_data[1:0];
        end
      end
    end
  end

  assign spi_miso = r_miso;
`else
  assign spi_miso = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdce62002_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cdce62002_responder: directed frames against cdce62002_responder.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cdce62002_responder;

  localparam logic [27:0] C_REG0_INIT = 28'h1234567;
  localparam logic [27:0] C_REG1_INIT = 28'h0ABCDEF;
  localparam int          C_HALF      = 5;

  logic        sysclk = 1'b0;
  logic        reset_INV;
  logic        spi_clk;
  logic        spi_le;
  logic        spi_mosi;
  logic        spi_miso;
  logic [27:0] reg0;
  logic [27:0] reg1;
  logic        write_strobe;
  logic [3:0]  write_addr;
  logic        eeprom_strobe;
  logic        frame_error;
  logic [7:0]  frame_count;

  int          n_total = 0;
  int          n_bad   = 0;
  int          ws_pulses;
  int          es_pulses;
  int          ws_first;
  logic [31:0] rx_word;
  logic [31:0] exp_rb;

  cdce62002_responder #(
    .REG0_INIT (C_REG0_INIT),
    .REG1_INIT (C_REG1_INIT)
  ) dut (
    .sysclk        (sysclk),
    .reset_INV     (reset_INV),
    .spi_clk       (spi_clk),
    .spi_le        (spi_le),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .reg0          (reg0),
    .reg1          (reg1),
    .write_strobe  (write_strobe),
    .write_addr    (write_addr),
    .eeprom_strobe (eeprom_strobe),
    .frame_error   (frame_error),
    .frame_count   (frame_count)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic frame_start();
    rx_word = 32'h0;
    spi_le  = 1'b0;
    wait_cycles(C_HALF);
  endtask

  task automatic send_bit(input logic b, input int idx);
    spi_mosi = b;
    wait_cycles(C_HALF);
    rx_word[idx] = spi_miso;
    spi_clk = 1'b1;
    wait_cycles(C_HALF);
    spi_clk = 1'b0;
  endtask

  // Raises LE and watches the strobes; ws_first is the cycle index of the first write pulse.
  task automatic frame_end();
    wait_cycles(C_HALF);
    spi_le    = 1'b1;
    ws_pulses = 0;
    es_pulses = 0;
    ws_first  = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge sysclk);
      if (write_strobe) begin
        ws_pulses++;
        if (ws_first < 0) ws_first = i;
      end
      if (eeprom_strobe) es_pulses++;
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input int nbits);
    frame_start();
    for (int i = 0; i < nbits; i++) send_bit(w[i], i);
    frame_end();
  endtask

  initial begin
    reset_INV = 1'b0;
    spi_le    = 1'b1;
    spi_clk   = 1'b0;
    spi_mosi  = 1'b0;
    wait_cycles(4);
    check("rst_reg0", {4'h0, reg0}, {4'h0, C_REG0_INIT});
    check("rst_reg1", {4'h0, reg1}, {4'h0, C_REG1_INIT});
    check("rst_strobes", {30'h0, write_strobe, eeprom_strobe}, 32'h0);
    check("rst_waddr", {28'h0, write_addr}, 32'h0);
    check("rst_ferr", {31'h0, frame_error}, 32'h0);
    check("rst_fcnt", {24'h0, frame_count}, 32'h0);
    check("rst_miso", {31'h0, spi_miso}, 32'h0);
    reset_INV = 1'b1;
    wait_cycles(6);

    // Write register 0
    send_frame(32'hABCDEF10, 32);
    check("w0_reg0", {4'h0, reg0}, 32'h0ABCDEF1);
    check("w0_ws_pulses", ws_pulses, 1);
    check("w0_ws_latency", ws_first, 4);
    check("w0_es_pulses", es_pulses, 0);
    check("w0_waddr", {28'h0, write_addr}, 32'h0);
    check("w0_fcnt", {24'h0, frame_count}, 32'd1);

    // Short frame, then a valid frame
    send_frame(32'h12345671, 31);
    check("short_reg1", {4'h0, reg1}, {4'h0, C_REG1_INIT});
    check("short_ferr", {31'h0, frame_error}, 32'h1);
    check("short_fcnt", {24'h0, frame_count}, 32'd1);
    check("short_ws_pulses", ws_pulses, 0);
    send_frame(32'h00000A51, 32);
    check("w1_reg1", {4'h0, reg1}, 32'h00000A5);
    check("w1_fcnt", {24'h0, frame_count}, 32'd2);
    check("w1_waddr", {28'h0, write_addr}, 32'h1);
    check("w1_ferr_sticky", {31'h0, frame_error}, 32'h1);

    // EEPROM copy, then overwrite reg0
    send_frame(32'h0000000F, 32);
    check("ee_es_pulses", es_pulses, 1);
    check("ee_ws_pulses", ws_pulses, 0);
    check("ee_waddr", {28'h0, write_addr}, 32'hF);
    check("ee_fcnt", {24'h0, frame_count}, 32'd3);
    send_frame(32'h55555550, 32);
    check("w0b_reg0", {4'h0, reg0}, 32'h5555555);

    // Read shadow0
    send_frame(32'h0000002E, 32);
    check("rdE_ws_pulses", ws_pulses, 0);
    check("rdE_waddr", {28'h0, write_addr}, 32'hE);
    check("rdE_fcnt", {24'h0, frame_count}, 32'd5);
`ifdef CDCE62002_RESPONDER_READBACK_EN
    exp_rb = 32'hABCDEF10;
`else
    exp_rb = 32'h0;
`endif
    send_frame(32'h00000003, 32);
    check("rb_shadow0", rx_word, exp_rb);
    check("rb_dummy_waddr", {28'h0, write_addr}, 32'h3);
    check("rb_dummy_reg0", {4'h0, reg0}, 32'h5555555);

    // Read reg1
    send_frame(32'h0000001E, 32);
`ifdef CDCE62002_RESPONDER_READBACK_EN
    exp_rb = 32'h00000A50;
`else
    exp_rb = 32'h0;
`endif
    send_frame(32'h00000002, 32);
    check("rb_reg1", rx_word, exp_rb);
    check("rb_fcnt", {24'h0, frame_count}, 32'd8);
    send_frame(32'h00000002, 32);
    check("rb_disarmed", rx_word, 32'h0);

    // Reset in the middle of a frame
    frame_start();
    for (int i = 0; i < 16; i++) send_bit(1'(i == 4 || i == 6 || i == 9 || i == 11), i);
    reset_INV = 1'b0;
    wait_cycles(3);
    reset_INV = 1'b1;
    wait_cycles(2);
    check("mid_reg0", {4'h0, reg0}, {4'h0, C_REG0_INIT});
    check("mid_fcnt", {24'h0, frame_count}, 32'd0);
    check("mid_ferr", {31'h0, frame_error}, 32'h0);
    frame_end();
    check("mid_ws_pulses", ws_pulses, 0);
    send_frame(32'h0000BEE1, 32);
    check("post_reg1", {4'h0, reg1}, 32'h0000BEE);
    check("post_fcnt", {24'h0, frame_count}, 32'd1);
    check("post_waddr", {28'h0, write_addr}, 32'h1);
    check("post_reg0", {4'h0, reg0}, {4'h0, C_REG0_INIT});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
